// File: rtl/ctu_mem_rsp_if.sv
// rtl/ctu_mem_rsp_if.sv - host/control-unit access bus for the search-unit RAM responder
interface ctu_mem_rsp_if #(
  parameter int A = 8,
  parameter int D = 8
);
  logic         ce_ctu;
  logic         we_ctu;
  logic         sel_ce_ctu;
  logic         sel_we_ctu;
  logic         sel_adr;
  logic [A-1:0] adr_ctu;
  logic [D-1:0] din_ctu;
  logic         ce_host;
  logic         we_host;
  logic [A-1:0] adr_host;
  logic [D-1:0] din_host;
  logic [D-1:0] dout;
  logic         dout_vld;
  logic         ready;
  logic         err_drop;

  modport master (
    output ce_ctu, we_ctu, sel_ce_ctu, sel_we_ctu, sel_adr, adr_ctu, din_ctu,
           ce_host, we_host, adr_host, din_host,
    input  dout, dout_vld, ready, err_drop
  );

  modport slave (
    input  ce_ctu, we_ctu, sel_ce_ctu, sel_we_ctu, sel_adr, adr_ctu, din_ctu,
           ce_host, we_host, adr_host, din_host,
    output dout, dout_vld, ready, err_drop
  );
endinterface

// File: rtl/ctu_mem_rsp.sv
// rtl/ctu_mem_rsp.sv - single-port RAM responder with post-reset clear sweep
module ctu_mem_rsp #(
  parameter int A = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         reset,
  ctu_mem_rsp_if.slave bus
);
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [D-1:0] mem [2**A];

  logic [0:0]   state;
  logic [A-1:0] clr_cnt;
  logic [D-1:0] dout_r;
  logic         dout_vld_r;
  logic         err_drop_r;

  logic         ce;
  logic         we;
  logic [A-1:0] adr;
  logic [D-1:0] din;
  logic         mem_we;
  logic [A-1:0] mem_adr;
  logic [D-1:0] mem_din;

  // Selects are independent; a known select keeps the unused port out of the path.
  always_comb begin
    ce  = bus.sel_ce_ctu ? bus.ce_ctu  : bus.ce_host;
    we  = bus.sel_we_ctu ? bus.we_ctu  : bus.we_host;
    adr = bus.sel_adr    ? bus.adr_ctu : bus.adr_host;
    din = bus.sel_adr    ? bus.din_ctu : bus.din_host;
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_adr = adr;
    mem_din = din;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem_we  = 1'b1;
        mem_adr = clr_cnt;
        mem_din = '0;
      end else if (ce && we) begin
        mem_we = 1'b1;
      end
    end
  end

  // Array has no reset; its contents are established by the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_adr] <= mem_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
      err_drop_r <= 1'b0;
    end else begin
      dout_vld_r <= 1'b0;
      err_drop_r <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          // Terminal-count compare: READY is entered once and the sweep never repeats.
          if (clr_cnt == {A{1'b1}}) begin
            state <= ST_READY;
          end
          if (ce) begin
            err_drop_r <= 1'b1;
          end
        end
        default: begin
          if (ce && !we) begin
            dout_r     <= mem[adr];
            dout_vld_r <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.dout     = dout_r;
  assign bus.dout_vld = dout_vld_r;
  assign bus.ready    = (state == ST_READY);
  assign bus.err_drop = err_drop_r;
endmodule

// File: tb/tb_ctu_mem_rsp.sv
// tb/tb_ctu_mem_rsp.sv - scoreboard bench for the RAM responder
module tb_ctu_mem_rsp;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  ctu_mem_rsp_if #(.A(8), .D(8)) bus ();

  ctu_mem_rsp #(.A(8), .D(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_reads  = 0;
  int n_rsp    = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read responses are matched in issue order.
  always @(negedge clk) begin
    if (!reset && bus.dout_vld) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dout_vld: got dout=0x%0h expected no response", bus.dout);
      end else begin
        chk("read_data", int'(bus.dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle();
    bus.ce_ctu  = 1'b0;
    bus.ce_host = 1'b0;
  endtask

  task automatic acc(input bit use_ctu, input bit wr, input logic [7:0] adr,
                     input logic [7:0] din, input logic [7:0] exp);
    bus.sel_ce_ctu = use_ctu;
    bus.sel_we_ctu = use_ctu;
    bus.sel_adr    = use_ctu;
    if (use_ctu) begin
      bus.ce_ctu = 1'b1; bus.we_ctu = wr; bus.adr_ctu = adr; bus.din_ctu = din;
      bus.ce_host = 1'($urandom); bus.we_host = 1'($urandom);
      bus.adr_host = 8'($urandom); bus.din_host = 8'($urandom);
    end else begin
      bus.ce_host = 1'b1; bus.we_host = wr; bus.adr_host = adr; bus.din_host = din;
      bus.ce_ctu = 1'($urandom); bus.we_ctu = 1'($urandom);
      bus.adr_ctu = 8'($urandom); bus.din_ctu = 8'($urandom);
    end
    if (!wr) begin
      exp_q.push_back(exp);
      n_reads++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_ready", int'(bus.ready), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_dout_vld", int'(bus.dout_vld), 0);
    chk("rst_err_drop", int'(bus.err_drop), 0);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int exp_cycles);
    int cnt = 0;
    while (!bus.ready && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk("ready_latency", cnt, exp_cycles);
  endtask

  initial begin
    bus.sel_ce_ctu = 1'b1; bus.sel_we_ctu = 1'b1; bus.sel_adr = 1'b1;
    bus.ce_ctu = 1'b0; bus.we_ctu = 1'b0; bus.adr_ctu = '0; bus.din_ctu = '0;
    bus.ce_host = 1'b0; bus.we_host = 1'b0; bus.adr_host = '0; bus.din_host = '0;

    // T1: sweep length and cleared contents
    do_reset();
    wait_ready(256);
    for (int i = 0; i < 256; i++) acc(1'b1, 1'b0, 8'(i), 8'h00, 8'h00);
    idle();
    @(negedge clk);

    // T2: control-unit write then read
    acc(1'b1, 1'b1, 8'h10, 8'hA5, 8'h00);
    acc(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
    idle();
    @(negedge clk);

    // T3: host port with the control-unit port toggling
    acc(1'b0, 1'b1, 8'hFF, 8'h3C, 8'h00);
    acc(1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C);
    acc(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
    idle();
    @(negedge clk);

    // T6: mixed selects, CE from ctu, WE/adr/data from host
    bus.sel_ce_ctu = 1'b1; bus.sel_we_ctu = 1'b0; bus.sel_adr = 1'b0;
    bus.ce_ctu = 1'b1; bus.we_ctu = 1'b0; bus.adr_ctu = 8'h08; bus.din_ctu = 8'hEE;
    bus.ce_host = 1'b0; bus.we_host = 1'b1; bus.adr_host = 8'h07; bus.din_host = 8'h5A;
    @(negedge clk);
    chk("mixed_no_dout_vld", int'(bus.dout_vld), 0);
    idle();
    acc(1'b1, 1'b0, 8'h07, 8'h00, 8'h5A);
    acc(1'b1, 1'b0, 8'h08, 8'h00, 8'h00);
    idle();
    @(negedge clk);

    // T5: reset aborts the sweep and re-clears the array
    acc(1'b1, 1'b1, 8'h20, 8'h11, 8'h00);
    acc(1'b1, 1'b0, 8'h20, 8'h00, 8'h11);
    idle();
    @(negedge clk);
    do_reset();
    repeat (100) @(negedge clk);
    chk("mid_sweep_not_ready", int'(bus.ready), 0);
    do_reset();
    wait_ready(256);
    acc(1'b1, 1'b0, 8'h20, 8'h00, 8'h00);
    acc(1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
    idle();
    @(negedge clk);

    // T4: access during the sweep is dropped and flagged
    do_reset();
    repeat (4) @(negedge clk);
    chk("err_drop_idle", int'(bus.err_drop), 0);
    bus.sel_ce_ctu = 1'b0; bus.sel_we_ctu = 1'b0; bus.sel_adr = 1'b0;
    bus.ce_host = 1'b1; bus.we_host = 1'b1; bus.adr_host = 8'h00; bus.din_host = 8'h77;
    @(negedge clk);
    chk("err_drop_pulse", int'(bus.err_drop), 1);
    idle();
    @(negedge clk);
    chk("err_drop_clear", int'(bus.err_drop), 0);
    wait_ready(250);
    acc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    idle();
    repeat (4) @(negedge clk);
    chk("ready_held", int'(bus.ready), 1);

    chk("rsp_count", n_rsp, n_reads);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
